// File: rtl/bcd_mult_pkg.sv
// Shared types and sizes for the two-requester multiply-and-convert sequencer.
package bcd_mult_pkg;

    localparam int MUL_STEPS  = 4;
    localparam int DAB_STEPS  = 8;
    localparam int OP_W       = 4;
    localparam int PROD_W     = 8;
    localparam int BCD_DIGITS = 3;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int DAB_W      = BCD_W + PROD_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic [3:0] dabble_adj(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: correct every BCD nibble, then shift the
// whole {bcd, binary} register left by one.
module bcd_dabble_step
    import bcd_mult_pkg::*;
(
    input  logic [DAB_W-1:0] dab_i,
    output logic [DAB_W-1:0] dab_o
);

    logic [DAB_W-1:0] adj;

    always_comb begin
        adj = dab_i;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            adj[PROD_W + 4*d +: 4] = dabble_adj(dab_i[PROD_W + 4*d +: 4]);
        end
        dab_o = {adj[DAB_W-2:0], 1'b0};
    end

endmodule

// File: rtl/bcd_mult_sequencer.sv
// Round-robin shared 4x4 shift-add multiplier followed by an iterative
// binary-to-BCD converter; returns product and three BCD digits per request.
module bcd_mult_sequencer
    import bcd_mult_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [OP_W-1:0]   req_x0,
    input  logic [OP_W-1:0]   req_y0,
    input  logic [OP_W-1:0]   req_x1,
    input  logic [OP_W-1:0]   req_y1,
    output logic [1:0]        req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [PROD_W-1:0] resp_product,
    output logic [3:0]        resp_bcd_hundreds,
    output logic [3:0]        resp_bcd_tens,
    output logic [3:0]        resp_bcd_ones
);

    localparam logic [2:0] MUL_LAST = 3'(MUL_STEPS - 1);
    localparam logic [2:0] DAB_LAST = 3'(DAB_STEPS - 1);

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [2:0]        step_q, step_d;
    logic [OP_W-1:0]   x_q, x_d;
    logic [OP_W-1:0]   y_q, y_d;
    logic              id_q, id_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic [DAB_W-1:0]  dab_q, dab_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_id_q, resp_id_d;
    logic [PROD_W-1:0] resp_prod_q, resp_prod_d;
    logic [BCD_W-1:0]  resp_bcd_q, resp_bcd_d;

    logic [1:0]        grant;
    logic [PROD_W-1:0] partial;
    logic [PROD_W-1:0] acc_sum;
    logic [DAB_W-1:0]  dab_next;

    bcd_dabble_step u_dabble_step (
        .dab_i (dab_q),
        .dab_o (dab_next)
    );

    // ptr_q names the requester that wins a tie; it flips away from whoever was just served.
    always_comb begin
        grant = 2'b00;
        if (state_q == IDLE && !reset) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    always_comb begin
        partial = y_q[step_q[1:0]] ? (PROD_W'(x_q) << step_q[1:0]) : '0;
        acc_sum = acc_q + partial;
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        step_d       = step_q;
        x_d          = x_q;
        y_d          = y_q;
        id_d         = id_q;
        acc_d        = acc_q;
        dab_d        = dab_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_prod_d  = resp_prod_q;
        resp_bcd_d   = resp_bcd_q;

        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    id_d    = grant[1];
                    x_d     = grant[1] ? req_x1 : req_x0;
                    y_d     = grant[1] ? req_y1 : req_y0;
                    acc_d   = '0;
                    step_d  = '0;
                    ptr_d   = ~grant[1];
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d = acc_sum;
                if (step_q == MUL_LAST) begin
                    step_d  = '0;
                    dab_d   = {{BCD_W{1'b0}}, acc_sum};
                    state_d = CONV;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            CONV: begin
                dab_d = dab_next;
                if (step_q == DAB_LAST) begin
                    step_d       = '0;
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_prod_d  = acc_q;
                    resp_bcd_d   = dab_next[DAB_W-1:PROD_W];
                    state_d      = DONE;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            step_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_prod_q  <= '0;
            resp_bcd_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            step_q       <= step_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_prod_q  <= resp_prod_d;
            resp_bcd_q   <= resp_bcd_d;
        end
    end

    // Datapath registers are only meaningful while the FSM owns them, so no reset.
    always_ff @(posedge clk) begin
        x_q   <= x_d;
        y_q   <= y_d;
        id_q  <= id_d;
        acc_q <= acc_d;
        dab_q <= dab_d;
    end

    assign req_ready         = grant;
    assign resp_valid        = resp_valid_q;
    assign resp_id           = resp_id_q;
    assign resp_product      = resp_prod_q;
    assign resp_bcd_hundreds = resp_bcd_q[11:8];
    assign resp_bcd_tens     = resp_bcd_q[7:4];
    assign resp_bcd_ones     = resp_bcd_q[3:0];

endmodule

// File: tb/tb_bcd_mult_sequencer.sv
// Scoreboard bench for bcd_mult_sequencer: table vectors plus arbitration,
// back-pressure, abort-by-reset and operand-change sequences.
module tb_bcd_mult_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [3:0] req_x0, req_y0, req_x1, req_y1;
    logic [1:0] req_ready;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_id;
    logic [7:0] resp_product;
    logic [3:0] resp_bcd_hundreds, resp_bcd_tens, resp_bcd_ones;

    bcd_mult_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_x0            (req_x0),
        .req_y0            (req_y0),
        .req_x1            (req_x1),
        .req_y1            (req_y1),
        .req_ready         (req_ready),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_id           (resp_id),
        .resp_product      (resp_product),
        .resp_bcd_hundreds (resp_bcd_hundreds),
        .resp_bcd_tens     (resp_bcd_tens),
        .resp_bcd_ones     (resp_bcd_ones)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [7:0] prod;
        logic [3:0] h, t, o;
    } exp_t;

    typedef struct {
        logic       id;
        logic [3:0] x, y;
        logic [7:0] prod;
        logic [3:0] h, t, o;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [3:0] x, input logic [3:0] y);
        exp_t e;
        int   p;
        p      = int'(x) * int'(y);
        e.id   = id;
        e.prod = 8'(p);
        e.h    = 4'(p / 100);
        e.t    = 4'((p / 10) % 10);
        e.o    = 4'(p % 10);
        return e;
    endfunction

    // Scoreboard: every handshake pops the oldest expected response.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                e = sb.pop_front();
                check("resp_id",       int'(resp_id),           int'(e.id));
                check("resp_product",  int'(resp_product),      int'(e.prod));
                check("resp_hundreds", int'(resp_bcd_hundreds), int'(e.h));
                check("resp_tens",     int'(resp_bcd_tens),     int'(e.t));
                check("resp_ones",     int'(resp_bcd_ones),     int'(e.o));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input logic [1:0] exp_g, input string name);
        int n = 0;
        while (req_ready == 2'b00 && n < 60) begin
            tick();
            n++;
        end
        check({name, "_grant"}, int'(req_ready), int'(exp_g));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic req_single(input logic id, input logic [3:0] x, input logic [3:0] y,
                              input exp_t e, input bit mutate);
        int n = 0;
        if (id) begin
            req_x1 = x; req_y1 = y; req_valid = 2'b10;
        end else begin
            req_x0 = x; req_y0 = y; req_valid = 2'b01;
        end
        sb.push_back(e);
        wait_grant(id ? 2'b10 : 2'b01, "single");
        tick();
        req_valid = 2'b00;
        while (!resp_valid && n < 40) begin
            tick();
            n++;
            if (mutate && n == 2) begin
                req_x0 = ~x; req_y0 = ~y; req_x1 = ~x; req_y1 = ~y;
            end
        end
        check("latency", n, 12);
        wait_drain();
    endtask

    task automatic run_pair(input logic [3:0] x0, input logic [3:0] y0,
                            input logic [3:0] x1, input logic [3:0] y1, input logic first);
        req_x0 = x0; req_y0 = y0; req_x1 = x1; req_y1 = y1;
        sb.push_back(first ? model(1'b1, x1, y1) : model(1'b0, x0, y0));
        sb.push_back(first ? model(1'b0, x0, y0) : model(1'b1, x1, y1));
        req_valid = 2'b11;
        wait_grant(first ? 2'b10 : 2'b01, "pair_first");
        tick();
        req_valid = first ? 2'b01 : 2'b10;
        wait_grant(first ? 2'b01 : 2'b10, "pair_second");
        tick();
        req_valid = 2'b00;
        wait_drain();
    endtask

    vec_t vt[8];

    initial begin : stim
        int seen;
        int n;

        vt[0] = '{1'b0, 4'd3,  4'd7,  8'd21,  4'd0, 4'd2, 4'd1};
        vt[1] = '{1'b1, 4'd15, 4'd15, 8'd225, 4'd2, 4'd2, 4'd5};
        vt[2] = '{1'b0, 4'd0,  4'd0,  8'd0,   4'd0, 4'd0, 4'd0};
        vt[3] = '{1'b1, 4'd9,  4'd11, 8'd99,  4'd0, 4'd9, 4'd9};
        vt[4] = '{1'b0, 4'd10, 4'd10, 8'd100, 4'd1, 4'd0, 4'd0};
        vt[5] = '{1'b1, 4'd8,  4'd13, 8'd104, 4'd1, 4'd0, 4'd4};
        vt[6] = '{1'b0, 4'd15, 4'd1,  8'd15,  4'd0, 4'd1, 4'd5};
        vt[7] = '{1'b1, 4'd12, 4'd12, 8'd144, 4'd1, 4'd4, 4'd4};

        reset = 1'b1; resp_ready = 1'b1; req_valid = 2'b00;
        req_x0 = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0;
        tick();
        req_valid = 2'b11;
        #1;
        check("rst_ready",      int'(req_ready),    0);
        check("rst_valid",      int'(resp_valid),   0);
        check("rst_id",         int'(resp_id),      0);
        check("rst_product",    int'(resp_product), 0);
        check("rst_digits",     int'({resp_bcd_hundreds, resp_bcd_tens, resp_bcd_ones}), 0);
        req_valid = 2'b00;
        tick();
        reset = 1'b0;

        // Both pending straight out of reset: requester 0 first, then 1.
        run_pair(4'd9, 4'd9, 4'd0, 4'd9, 1'b0);
        // Serve 0 alone, so a following tie goes to requester 1.
        req_single(1'b0, 4'd2, 4'd3, model(1'b0, 4'd2, 4'd3), 1'b0);
        run_pair(4'd4, 4'd5, 4'd6, 4'd7, 1'b1);

        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.id = vt[i].id; e.prod = vt[i].prod;
            e.h = vt[i].h; e.t = vt[i].t; e.o = vt[i].o;
            req_single(vt[i].id, vt[i].x, vt[i].y, e, 1'b0);
        end

        // Operands change two cycles after acceptance; latched values must be used.
        req_single(1'b0, 4'd13, 4'd11, model(1'b0, 4'd13, 4'd11), 1'b1);

        // Back-pressure: result held for 20 cycles with a competing request pending.
        resp_ready = 1'b0;
        req_x1 = 4'd7; req_y1 = 4'd6; req_valid = 2'b10;
        sb.push_back(model(1'b1, 4'd7, 4'd6));
        wait_grant(2'b10, "hold");
        tick();
        req_x0 = 4'd1; req_y0 = 4'd1; req_valid = 2'b01;
        n = 0;
        while (!resp_valid && n < 40) begin
            tick();
            n++;
        end
        check("hold_latency", n, 12);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_outputs", int'({resp_valid, resp_id, resp_product,
                                        resp_bcd_hundreds, resp_bcd_tens, resp_bcd_ones}),
                  int'({1'b1, 1'b1, 8'd42, 4'd0, 4'd4, 4'd2}));
            check("hold_ready", int'(req_ready), 0);
        end
        resp_ready = 1'b1;
        tick();
        check("release_valid", int'(resp_valid), 0);
        check("release_idle",  int'(req_ready),  1);
        req_valid = 2'b00;
        check("hold_drain", sb.size(), 0);

        // Reset lands on the 4th conversion step; the operation must vanish.
        req_x0 = 4'd5; req_y0 = 4'd5; req_valid = 2'b01;
        wait_grant(2'b01, "abort");
        tick();
        req_valid = 2'b00;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        check("abort_valid",   int'(resp_valid),   0);
        check("abort_id",      int'(resp_id),      0);
        check("abort_product", int'(resp_product), 0);
        check("abort_digits",  int'({resp_bcd_hundreds, resp_bcd_tens, resp_bcd_ones}), 0);
        req_valid = 2'b11;
        #1;
        check("abort_rst_ready", int'(req_ready), 0);
        req_valid = 2'b00;
        tick();
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            tick();
            if (resp_valid) seen++;
        end
        check("abort_no_resp", seen, 0);
        // Pointer must be back on requester 0 after reset.
        run_pair(4'd3, 4'd4, 4'd5, 4'd6, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
